// File: rtl/oled_spi_serializer.sv
// Write-only SPI serializer for an SSD1306-class OLED: shifts one 1..4 byte
// command MSB-first with SCK idling high (mode 3) and a per-word DCN line.
module oled_spi_serializer #(
  parameter int CBITS = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_wr,
  input  logic        i_dbit,
  input  logic [31:0] i_word,
  input  logic [1:0]  i_len,
  output logic        o_busy,
  output logic        o_sck,
  output logic        o_mosi,
  output logic        o_dbit
);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [CBITS-1:0]  div_q, div_d;
  logic [5:0]        bits_q, bits_d;
  logic [31:0]       sr_q, sr_d;
  logic              sck_q, sck_d;
  logic              mosi_q, mosi_d;
  logic              dbit_q, dbit_d;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      div_q   <= '0;
      bits_q  <= '0;
      sr_q    <= '0;
      sck_q   <= 1'b1;
      mosi_q  <= 1'b1;
      dbit_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bits_q  <= bits_d;
      sr_q    <= sr_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
      dbit_q  <= dbit_d;
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bits_d  = bits_q;
    sr_d    = sr_q;
    sck_d   = sck_q;
    mosi_d  = mosi_q;
    dbit_d  = dbit_q;
    case (state_q)
      IDLE: begin
        sck_d = 1'b1;
        if (i_wr) begin
          state_d = SHIFT;
          sr_d    = i_word;
          bits_d  = 6'({i_len, 3'b000}) + 6'd8;
          div_d   = '0;
          // First low phase begins on the very next cycle with bit 31 already on MOSI.
          sck_d   = 1'b0;
          mosi_d  = i_word[31];
          dbit_d  = i_dbit;
        end
      end
      SHIFT: begin
        div_d = div_q + CBITS'(1);
        sck_d = div_d[CBITS-1];
        if (div_q == '1) begin
          bits_d = bits_q - 6'd1;
          sr_d   = {sr_q[30:0], 1'b0};
          if (bits_q == 6'd1) begin
            // Last high phase done: park SCK high, MOSI keeps the final bit.
            state_d = IDLE;
            sck_d   = 1'b1;
          end else begin
            mosi_d = sr_q[30];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_busy = (state_q == SHIFT);
  assign o_sck  = sck_q;
  assign o_mosi = mosi_q;
  assign o_dbit = dbit_q;

endmodule
